// File: rtl/sfifo_pkt_pkg.sv
// Shared types and constants for the FIFO packet reader.
package sfifo_pkt_pkg;

  localparam int DW          = 16;
  localparam int LEN_W       = 5;
  localparam int MAX_LEN     = 31;
  localparam int CNT_W       = 16;
  localparam int FIFO_DEPTH  = 32;
  // The FIFO reports a 5-bit occupancy that wraps to 0 when full.
  localparam int FIFO_CNT_W  = 5;
  // One extra bit so a full FIFO (32 words) can be represented.
  localparam int AVAIL_W     = FIFO_CNT_W + 1;
  localparam int WORD_W      = DW + 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } stream_word_t;

  // A header is legal when its length field is 1..MAX_LEN.
  function automatic logic len_legal(input logic [LEN_W-1:0] len);
    return (len != '0) && (AVAIL_W'(len) <= AVAIL_W'(MAX_LEN));
  endfunction

endpackage

// File: rtl/sfifo_pkt_reader_if.sv
// Packet output stream: valid/ready handshake with sop/eop framing.
interface sfifo_pkt_reader_if #(
  parameter int DW = 16
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;

  modport master (
    output out_valid,
    output out_data,
    output out_sop,
    output out_eop,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_sop,
    input  out_eop,
    output out_ready
  );
endinterface

// File: rtl/pipe_skid_w18.sv
// Two-entry valid/ready skid buffer for an 18-bit word. Outputs come
// straight from the head register so the downstream sees registered data.
module pipe_skid_w18 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_word
);

  logic [17:0] slot0_reg;
  logic [17:0] slot1_reg;
  logic [1:0]  count_reg;
  logic        push;
  logic        pop;

  // Ready only depends on occupancy, never on the same-cycle pop.
  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign out_word  = slot0_reg;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage update: slot0 is always the head, slot1 the overflow entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_reg <= '0;
      slot1_reg <= '0;
      count_reg <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) slot0_reg <= in_word;
          else                   slot1_reg <= in_word;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          slot0_reg <= slot1_reg;
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd1) begin
            slot0_reg <= in_word;
          end else begin
            slot0_reg <= slot1_reg;
            slot1_reg <= in_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sfifo_pkt_reader.sv
// Drains length-prefixed packets from a FWFT sync FIFO onto a framed
// valid/ready stream. A packet is started only once it is fully resident,
// so the payload never underflows mid-packet. Bad headers are dropped.
module sfifo_pkt_reader
  import sfifo_pkt_pkg::*;
#(
  parameter int CNT_W_P = CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         fifo_dout,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  input  logic [FIFO_CNT_W-1:0] fifo_data_count,
  output logic                  fifo_rd_en,
  sfifo_pkt_reader_if.master    strm,
  output logic                  hdr_err,
  output logic [CNT_W_P-1:0]    pkt_cnt,
  output logic [CNT_W_P-1:0]    err_cnt
);

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   rem_reg, rem_next;
  logic               settle_reg, settle_next;
  logic [CNT_W_P-1:0] pkt_cnt_reg, err_cnt_reg;
  logic               pkt_inc, err_inc;

  logic [AVAIL_W-1:0] avail;
  logic [LEN_W-1:0]   hdr_len;
  logic [AVAIL_W-1:0] hdr_need;
  logic               hdr_ok;

  logic               skid_rdy;
  logic               skid_push;
  stream_word_t       skid_in;
  stream_word_t       skid_out;
  logic               skid_out_valid;

  // Full FIFO reads back a count of 0, so substitute the depth.
  assign avail    = fifo_full ? AVAIL_W'(FIFO_DEPTH) : AVAIL_W'(fifo_data_count);
  assign hdr_len  = fifo_dout[LEN_W-1:0];
  assign hdr_need = AVAIL_W'(hdr_len) + AVAIL_W'(1);
  assign hdr_ok   = len_legal(hdr_len);

  // State, remaining-length, settle flag and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      rem_reg     <= '0;
      settle_reg  <= 1'b0;
      pkt_cnt_reg <= '0;
      err_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      rem_reg    <= rem_next;
      settle_reg <= settle_next;
      if (pkt_inc) pkt_cnt_reg <= pkt_cnt_reg + CNT_W_P'(1);
      if (err_inc) err_cnt_reg <= err_cnt_reg + CNT_W_P'(1);
    end
  end

  // Header admission and payload forwarding. After an eop pop one idle
  // cycle (settle) is inserted so the FIFO occupancy reflects the pops
  // before the next header's residency check.
  always_comb begin
    state_next  = state_reg;
    rem_next    = rem_reg;
    settle_next = 1'b0;
    fifo_rd_en  = 1'b0;
    skid_push   = 1'b0;
    skid_in     = '{data: fifo_dout, sop: 1'b0, eop: 1'b0};
    hdr_err     = 1'b0;
    pkt_inc     = 1'b0;
    err_inc     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!settle_reg && !fifo_empty) begin
          if (!hdr_ok) begin
            fifo_rd_en = 1'b1;
            hdr_err    = 1'b1;
            err_inc    = 1'b1;
          end else if ((avail >= hdr_need) && skid_rdy) begin
            fifo_rd_en  = 1'b1;
            skid_push   = 1'b1;
            skid_in.sop = 1'b1;
            rem_next    = hdr_len;
            state_next  = SEND;
          end
        end
      end
      SEND: begin
        if (!fifo_empty && skid_rdy) begin
          fifo_rd_en  = 1'b1;
          skid_push   = 1'b1;
          skid_in.eop = (rem_reg == LEN_W'(1));
          rem_next    = rem_reg - LEN_W'(1);
          if (rem_reg == LEN_W'(1)) begin
            pkt_inc     = 1'b1;
            state_next  = IDLE;
            settle_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  pipe_skid_w18 u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (skid_push),
    .in_ready  (skid_rdy),
    .in_word   (skid_in),
    .out_valid (skid_out_valid),
    .out_ready (strm.out_ready),
    .out_word  (skid_out)
  );

  assign strm.out_valid = skid_out_valid;
  assign strm.out_data  = skid_out.data;
  assign strm.out_sop   = skid_out.sop && skid_out_valid;
  assign strm.out_eop   = skid_out.eop && skid_out_valid;
  assign pkt_cnt        = pkt_cnt_reg;
  assign err_cnt        = err_cnt_reg;

`ifndef SYNTHESIS
  // Popping an empty FIFO would corrupt its pointers.
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(fifo_rd_en && fifo_empty));
`endif

endmodule

// File: tb/tb_sfifo_pkt_reader.sv
// Scoreboard bench: FWFT FIFO model feeds the reader, expected stream
// words are queued when written and compared as the stream accepts them.
module tb_sfifo_pkt_reader;
  import sfifo_pkt_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] fifo_dout;
  logic        fifo_empty, fifo_full;
  logic [4:0]  fifo_data_count;
  logic        fifo_rd_en, hdr_err;
  logic [15:0] pkt_cnt, err_cnt;

  sfifo_pkt_reader_if #(.DW(16)) strm ();

  sfifo_pkt_reader dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_dout       (fifo_dout),
    .fifo_empty      (fifo_empty),
    .fifo_full       (fifo_full),
    .fifo_data_count (fifo_data_count),
    .fifo_rd_en      (fifo_rd_en),
    .strm            (strm),
    .hdr_err         (hdr_err),
    .pkt_cnt         (pkt_cnt),
    .err_cnt         (err_cnt)
  );

  // FIFO model: 16 x 32 first-word-fall-through, count reads 0 when full.
  logic [15:0] fmem [0:31];
  logic [4:0]  frd, fwr;
  logic [5:0]  fcnt;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;

  assign fifo_dout       = fmem[frd];
  assign fifo_empty      = (fcnt == 6'd0);
  assign fifo_full       = (fcnt == 6'd32);
  assign fifo_data_count = fcnt[4:0];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      frd  <= '0;
      fwr  <= '0;
      fcnt <= '0;
    end else begin
      if (fifo_rd_en && fcnt != 6'd0) frd <= frd + 5'd1;
      if (wr_en && fcnt != 6'd32) begin
        fmem[fwr] <= wr_data;
        fwr       <= fwr + 5'd1;
      end
      fcnt <= fcnt + 6'(wr_en && fcnt != 6'd32) - 6'(fifo_rd_en && fcnt != 6'd0);
    end
  end

  int          n_vec = 0;
  int          n_miss = 0;
  logic [17:0] exp_q[$];
  int          acc_cyc[$];
  int          n_acc = 0, n_exp = 0, n_hdr_err = 0, n_rd = 0, cyc = 0;
  int          pkt_exp = 0, err_exp = 0;
  int          ready_mode = 0;
  logic        hold_pending = 1'b0;
  logic [18:0] held;
  logic [17:0] got_w, exp_w;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives out_ready and monitors the stream each falling edge.
  initial begin
    strm.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      case (ready_mode)
        0:       strm.out_ready = 1'b1;
        1:       strm.out_ready = ~strm.out_ready;
        default: strm.out_ready = 1'b0;
      endcase
      if (rst) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending)
          check_eq("stall_hold", {strm.out_valid, strm.out_data, strm.out_sop, strm.out_eop}, held);
        if (strm.out_valid && !strm.out_ready) begin
          hold_pending = 1'b1;
          held = {strm.out_valid, strm.out_data, strm.out_sop, strm.out_eop};
        end else begin
          hold_pending = 1'b0;
        end
        if (strm.out_valid && strm.out_ready) begin
          got_w = {strm.out_data, strm.out_sop, strm.out_eop};
          $display("[%0d] word %h sop=%0d eop=%0d", cyc, strm.out_data, strm.out_sop, strm.out_eop);
          acc_cyc.push_back(cyc);
          n_acc++;
          if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            check_eq("out_word", got_w, exp_w);
          end
        end
        if (hdr_err) n_hdr_err++;
        if (fifo_rd_en) n_rd++;
      end
    end
  end

  task automatic wr(input logic [15:0] w);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = w;
  endtask

  task automatic wr_done();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic exp_push(input logic [15:0] w, input logic sop, input logic eop);
    exp_q.push_back({w, sop, eop});
    n_exp++;
  endtask

  task automatic send_pkt(input logic [15:0] hdr, input int n, input logic [15:0] base);
    logic [15:0] w;
    wr(hdr);
    exp_push(hdr, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      w = base + 16'(i);
      wr(w);
      exp_push(w, 1'b0, i == n - 1);
    end
    wr_done();
    pkt_exp++;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_drain"}, exp_q.size(), 0);
    repeat (4) @(negedge clk);
    check_eq({tag, "_words"}, n_acc, n_exp);
    check_eq({tag, "_pkt_cnt"}, pkt_cnt, pkt_exp);
    check_eq({tag, "_err_cnt"}, err_cnt, err_exp);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b, rd0, e0, t;
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_valid", strm.out_valid, 0);
    check_eq("rst_rd_en", fifo_rd_en, 0);
    check_eq("rst_pkt_cnt", pkt_cnt, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single packet, 4 consecutive output cycles
    b = acc_cyc.size();
    send_pkt(16'h0003, 3, 16'h00A1);
    drain("single");
    check_eq("single_span", acc_cyc[b+3] - acc_cyc[b], 3);

    // Partial residency: no read until all 5 words present
    b = acc_cyc.size();
    rd0 = n_rd;
    exp_push(16'h0004, 1'b1, 1'b0);
    exp_push(16'h00B1, 1'b0, 1'b0);
    exp_push(16'h00B2, 1'b0, 1'b0);
    exp_push(16'h00B3, 1'b0, 1'b0);
    exp_push(16'h00B4, 1'b0, 1'b1);
    pkt_exp++;
    wr(16'h0004); wr(16'h00B1); wr(16'h00B2); wr_done();
    repeat (8) @(negedge clk);
    check_eq("partial_no_rd", n_rd - rd0, 0);
    wr(16'h00B3); wr(16'h00B4); wr_done();
    drain("partial");
    check_eq("partial_span", acc_cyc[b+4] - acc_cyc[b], 4);

    // Bad headers dropped with pulses, then a legal packet
    e0 = n_hdr_err;
    wr(16'h0000); wr(16'h0020); wr_done();
    err_exp += 2;
    repeat (4) @(negedge clk);
    check_eq("bad_hdr_pulses", n_hdr_err - e0, 2);
    send_pkt(16'h0001, 1, 16'h00C1);
    drain("bad_hdr");

    // 31-word packet fills the FIFO; ready toggles every cycle
    ready_mode = 1;
    send_pkt(16'h001F, 31, 16'hD000);
    drain("backpressure");
    ready_mode = 0;
    repeat (2) @(negedge clk);

    // Back-to-back 1-word packets: one bubble between them
    b = acc_cyc.size();
    exp_push(16'h0001, 1'b1, 1'b0);
    exp_push(16'h0E01, 1'b0, 1'b1);
    exp_push(16'h0001, 1'b1, 1'b0);
    exp_push(16'h0E02, 1'b0, 1'b1);
    pkt_exp += 2;
    wr(16'h0001); wr(16'h0E01); wr(16'h0001); wr(16'h0E02); wr_done();
    drain("b2b");
    check_eq("b2b_gap0", acc_cyc[b+1] - acc_cyc[b], 1);
    check_eq("b2b_gap1", acc_cyc[b+2] - acc_cyc[b+1], 2);
    check_eq("b2b_gap2", acc_cyc[b+3] - acc_cyc[b+2], 1);

    // Reset after two of the packet's words are accepted
    b = n_acc;
    send_pkt(16'h0005, 5, 16'h00E1);
    t = 0;
    while (n_acc < b + 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check_eq("mid_reached", n_acc - b, 2);
    #1 rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", strm.out_valid, 0);
    check_eq("mid_rst_sop", strm.out_sop, 0);
    check_eq("mid_rst_eop", strm.out_eop, 0);
    check_eq("mid_rst_data", strm.out_data, 0);
    check_eq("mid_rst_rd_en", fifo_rd_en, 0);
    check_eq("mid_rst_hdr_err", hdr_err, 0);
    check_eq("mid_rst_pkt_cnt", pkt_cnt, 0);
    check_eq("mid_rst_err_cnt", err_cnt, 0);
    exp_q.delete();
    n_exp = n_acc;
    pkt_exp = 0;
    err_exp = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_pkt(16'h0002, 2, 16'h00F1);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sfifo_pkt_reader.md
Name: sfifo_pkt_reader

Overview:
Read-side controller for the 16-bit x 32 first-word-fall-through sync FIFO (sfifo_ft_w16_d32) used for packet/descriptor queues. It drains length-prefixed packets from the FIFO and presents them on a valid/ready stream with sop/eop framing. A packet starts only when the whole packet is resident in the FIFO, so a started packet is never stalled by a FIFO underflow. Malformed headers are dropped and flagged.

Parameters:
DW, 16, FIFO/stream data width
LEN_W, 5, header length field width (bits [LEN_W-1:0] of header)
MAX_LEN, 31, largest legal payload length in words (header + payload <= FIFO depth 32)
CNT_W, 16, width of packet/error statistics counters

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
fifo_dout  in  DW  FIFO head word (valid when fifo_empty=0)
fifo_empty  in  1  FIFO empty
fifo_full  in  1  FIFO full
fifo_data_count  in  5  FIFO occupancy (reads 0 when full)
fifo_rd_en  out  1  pop FIFO head this cycle
out_valid  out  1  stream word valid
out_ready  in  1  downstream accepts word
out_data  out  DW  stream word
out_sop  out  1  first word of packet (header)
out_eop  out  1  last word of packet
hdr_err  out  1  one-cycle pulse: bad header dropped
pkt_cnt  out  CNT_W  packets fully forwarded (eop accepted into skid)
err_cnt  out  CNT_W  headers dropped

Behaviour:
- Reset (async, active-high): state=IDLE, rem=0, skid buffer empty; out_valid=0, out_sop=0, out_eop=0, out_data=0, fifo_rd_en=0, hdr_err=0, pkt_cnt=0, err_cnt=0. The FIFO shares rst; reset mid-packet discards the partial packet with no eop emitted.
- avail = fifo_full ? 32 : fifo_data_count (6-bit).
- Header: LEN = fifo_dout[LEN_W-1:0]; legal iff 1 <= LEN <= MAX_LEN. Header word is forwarded unmodified as the sop word.
- skid_rdy = skid buffer has at least one free slot.
- IDLE: if !fifo_empty and LEN illegal -> fifo_rd_en=1 (drop header), hdr_err=1 for that cycle, err_cnt+1, stay IDLE.
  If !fifo_empty, LEN legal, avail >= LEN+1, skid_rdy -> fifo_rd_en=1, push {header, sop=1, eop=0}, rem<=LEN, go to SEND. Otherwise wait with fifo_rd_en=0.
- SEND: fifo_rd_en = !fifo_empty && skid_rdy. Each pop pushes {word, sop=0, eop=(rem==1)} and decrements rem. Pop with rem==1 -> pkt_cnt+1, go to IDLE.
- Back-to-back: the next header is evaluated the cycle after the eop pop, giving 1 bubble cycle of FIFO reads. This guarantees fifo_data_count has settled.
- fifo_rd_en is never asserted when fifo_empty=1. Popping an empty FIFO is a design error; add an assertion.
- Output stage: 2-entry skid buffer of {DW data, sop, eop}. out_* come directly from skid registers. Latency: pop in cycle N -> out_valid in N+1. Throughput is 1 word/cycle while out_ready=1. out_valid is held with stable data/sop/eop until out_ready.
- Counters wrap modulo 2^CNT_W.
- Simultaneous events: skid push and pop in the same cycle are both honoured. hdr_err and a SEND pop cannot coincide because they are state-exclusive.

Decomposition:
- Package sfifo_pkt_pkg: DW, LEN_W, MAX_LEN, FIFO_DEPTH=32, state enum {IDLE, SEND}, stream-word struct {data, sop, eop}.
- Sub-module: pipe_skid_w18, a 2-entry valid/ready skid buffer for the 18-bit {data, sop, eop} word, with its own async active-high rst.

Test Plan:
- Single packet: write header 0x0003 plus 3 payload words A1,A2,A3; out_ready=1 -> out stream 0x0003(sop), A1, A2, A3(eop) on 4 consecutive cycles; pkt_cnt=1.
- Partial residency: write header 0x0004 plus 2 payload words -> fifo_rd_en stays 0. Add 2 more words -> packet streams 5 words; no read while avail < 5.
- Bad headers: header 0x0000, then header 0x0020 with LEN field 0 -> two hdr_err pulses, err_cnt=2, nothing output. A following legal packet forwards normally.
- Backpressure: 31-word packet with FIFO full (data_count=0, full=1) must start. Toggle out_ready 1/0 every cycle -> all 32 words in order, no loss or duplication, held stable while stalled.
- Back-to-back: two 1-word packets queued -> outputs hdr1(sop), p1(eop), hdr2(sop), p2(eop) with exactly 1 bubble between packets.
- Reset mid-packet: assert rst after 2 of 5 words are accepted -> all outputs return to reset values immediately, state=IDLE. After release, a new packet streams cleanly.
